sp_ddsm_ramp_ctrl: RTL and testbench

- Controller in front of the 3-stage sp_mash111 SP-MASH modulator.
- Owns the modulator's fractional input word and moves it from its current value to a new target in programmable steps, with a programmable dwell between steps. This gives glitch-free, rate-limited frequency changes.
- Software/upper FSM loads target/step/dwell through a valid/ready handshake; the block reports busy and a one-cycle done pulse.

---
 rtl/sp_ddsm_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_sp_ddsm_ramp_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ddsm_ramp_ctrl.sv
// Rate-limited ramp controller for the SP-MASH fractional input word.
// Moves x_o toward a loaded target in bounded steps with a programmable dwell between steps.
module sp_ddsm_ramp_ctrl #(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [WIDTH-1:0]   cfg_target_i,
    input  logic [WIDTH-1:0]   cfg_step_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic               abort_i,
    output logic [WIDTH-1:0]   x_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]     tgt_ext;
    logic [WIDTH:0]     up_sum;
    logic [WIDTH:0]     dn_diff;
    logic [WIDTH-1:0]   next_x;
    logic               cfg_accept;

    assign cfg_ready_o = (state_q == ST_IDLE) & ~abort_i;
    assign cfg_accept  = cfg_valid_i & cfg_ready_o;

    assign x_o    = x_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    // Next step value clamped to the target; the extra MSB catches overflow and borrow.
    always_comb begin
        tgt_ext = {1'b0, target_q};
        up_sum  = {1'b0, x_q} + {1'b0, step_q};
        dn_diff = {1'b0, x_q} - {1'b0, step_q};
        next_x  = target_q;
        if (step_q != '0) begin
            if (target_q > x_q) begin
                next_x = (up_sum > tgt_ext) ? target_q : up_sum[WIDTH-1:0];
            end else if (target_q < x_q) begin
                next_x = (dn_diff[WIDTH] || (dn_diff < tgt_ext)) ? target_q : dn_diff[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        target_d = target_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (cfg_accept) begin
                    target_d = cfg_target_i;
                    step_d   = cfg_step_i;
                    dwell_d  = cfg_dwell_i;
                    busy_d   = 1'b1;
                    state_d  = ST_RAMP;
                end
            end

            ST_RAMP: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (next_x == target_q) begin
                    x_d     = target_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    x_d = next_x;
                    if (dwell_q != '0) begin
                        cnt_d   = dwell_q;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                    if (cnt_q == DWELL_W'(1)) begin
                        state_d = ST_RAMP;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sp_ddsm_ramp_ctrl.sv
// Self-checking bench for sp_ddsm_ramp_ctrl: expected traces come from an integer ramp model.
module tb_sp_ddsm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [8:0] cfg_target_i = '0;
    logic [8:0] cfg_step_i = '0;
    logic [7:0] cfg_dwell_i = '0;
    logic       abort_i = 1'b0;
    logic [8:0] x_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;
    int model_x = 0;

    sp_ddsm_ramp_ctrl #(.WIDTH(9), .DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_target_i (cfg_target_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_dwell_i  (cfg_dwell_i),
        .abort_i      (abort_i),
        .x_o          (x_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_ramp(input int tgt, input int stp, input int dw, input bit noise);
        int vals[$];
        int cur;
        int per;
        int last;
        int idx;
        cur = model_x;
        if (stp == 0 || cur == tgt) begin
            vals.push_back(tgt);
        end else begin
            while (cur != tgt) begin
                if (tgt > cur) cur = (cur + stp > tgt) ? tgt : cur + stp;
                else           cur = (cur - stp < tgt) ? tgt : cur - stp;
                vals.push_back(cur);
            end
        end
        per  = dw + 1;
        last = (vals.size() - 1) * per + 1;

        cfg_valid_i  = 1'b1;
        cfg_target_i = 9'(tgt);
        cfg_step_i   = 9'(stp);
        cfg_dwell_i  = 8'(dw);
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ramp_ready: got %0b want 1", cfg_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || x_o !== 9'(model_x) || done_o !== 1'b0) begin
            errors++;
            $display("FAIL ramp_accept: got x=%0d busy=%0b done=%0b want x=%0d busy=1 done=0",
                     x_o, busy_o, done_o, model_x);
        end
        for (int o = 1; o <= last; o++) begin
            cfg_valid_i  = noise;
            cfg_target_i = 9'($urandom_range(0, 511));
            cfg_step_i   = 9'($urandom_range(0, 511));
            cfg_dwell_i  = 8'($urandom_range(0, 255));
            @(posedge clk);
            @(negedge clk);
            idx = (o - 1) / per;
            checks++;
            if (x_o !== 9'(vals[idx]) || done_o !== (o == last) || busy_o !== (o != last)) begin
                errors++;
                $display("FAIL ramp_trace t=%0d s=%0d d=%0d off=%0d: got x=%0d busy=%0b done=%0b want x=%0d busy=%0b done=%0b",
                         tgt, stp, dw, o, x_o, busy_o, done_o, vals[idx], (o != last), (o == last));
            end
        end
        cfg_valid_i = 1'b0;
        model_x = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (x_o !== 9'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: got x=%0d busy=%0b done=%0b ready=%0b want 0 0 0 1",
                     x_o, busy_o, done_o, cfg_ready_o);
        end
        model_x = 0;
    endtask

    task automatic test_single_done();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || x_o !== 9'(model_x)) begin
            errors++;
            $display("FAIL done_single: got x=%0d busy=%0b done=%0b want x=%0d busy=0 done=0",
                     x_o, busy_o, done_o, model_x);
        end
    endtask

    task automatic test_directed();
        run_ramp(100, 30, 0, 1'b0);
        test_single_done();
        run_ramp(40, 25, 2, 1'b0);
        run_ramp(500, 0, 0, 1'b0);
        run_ramp(511, 300, 0, 1'b0);
        run_ramp(0, 300, 0, 1'b0);
        run_ramp(257, 0, 0, 1'b0);
        run_ramp(257, 5, 0, 1'b0);
        test_single_done();
        run_ramp(0, 0, 0, 1'b0);
        run_ramp(300, 150, 255, 1'b0);
    endtask

    task automatic test_abort();
        run_ramp(0, 0, 0, 1'b0);
        cfg_valid_i  = 1'b1;
        cfg_target_i = 9'd200;
        cfg_step_i   = 9'd10;
        cfg_dwell_i  = 8'd3;
        @(posedge clk);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (x_o !== 9'd30 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got x=%0d busy=%0b want x=30 busy=1", x_o, busy_o);
        end
        abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (x_o !== 9'd30 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got x=%0d busy=%0b done=%0b ready=%0b want 30 0 0 0",
                     x_o, busy_o, done_o, cfg_ready_o);
        end
        cfg_valid_i  = 1'b1;
        cfg_target_i = 9'd100;
        cfg_step_i   = 9'd0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (x_o !== 9'd30 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_block: got x=%0d busy=%0b done=%0b want 30 0 0",
                     x_o, busy_o, done_o);
        end
        cfg_valid_i = 1'b0;
        abort_i = 1'b0;
        model_x = 30;
        run_ramp(100, 7, 1, 1'b0);
    endtask

    task automatic test_reset_mid_ramp();
        cfg_valid_i  = 1'b1;
        cfg_target_i = 9'(model_x > 255 ? 0 : 511);
        cfg_step_i   = 9'd10;
        cfg_dwell_i  = 8'd0;
        @(posedge clk);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (x_o !== 9'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got x=%0d busy=%0b done=%0b ready=%0b want 0 0 0 1",
                     x_o, busy_o, done_o, cfg_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_x = 0;
    endtask

    task automatic test_random();
        int tgt;
        int stp;
        int dw;
        for (int i = 0; i < 25; i++) begin
            tgt = $urandom_range(0, 511);
            stp = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(16, 511);
            dw  = $urandom_range(0, 5);
            run_ramp(tgt, stp, dw, 1'b1);
        end
        test_single_done();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid_ramp();
        test_random();
        test_back_to_back_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic test_back_to_back_zero();
        run_ramp(model_x, 9, 0, 1'b0);
        run_ramp(123, 0, 0, 1'b0);
        run_ramp(123, 0, 4, 1'b0);
    endtask

endmodule
